// File: rtl/axis_1553_encoder.sv
// AXI-Stream to MIL-STD-1553 Manchester II word transmitter.
// Each accepted beat is sent as a 3-bit-time sync, 16 data bits (MSB first)
// and one parity bit. A configurable idle gap follows before the next word.
// Valid/ready: a beat transfers on the rising edge where s_axis_tvalid and
// s_axis_tready are both high; tready is high only while the FSM is IDLE, and
// tdata/tuser/parity_set are captured on that same edge.
module axis_1553_encoder #(
   parameter int clock_speed = 20000000,
   parameter int gap_bits    = 4,
   parameter bit invert_data = 1'b0
) (
   input  logic        aclk,
   input  logic        arstn,
   input  logic        parity_set,
   input  logic [15:0] s_axis_tdata,
   input  logic [7:0]  s_axis_tuser,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [1:0]  diff,
   output logic        busy,
   output logic        tx_err,
   output logic [2:0]  dbg_state
);

   localparam int CPB     = clock_speed / 1000000;
   localparam int HB      = CPB / 2;
   localparam int GAP_CYC = gap_bits * CPB;

   generate
      if (clock_speed % 2000000 != 0) begin : g_bad_clock
         $error("axis_1553_encoder: clock_speed must be a multiple of 2 MHz");
      end
      if (gap_bits < 0) begin : g_bad_gap
         $error("axis_1553_encoder: gap_bits must not be negative");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, SYNC, DATA, PAR, GAP} state_t;

   state_t      state, state_nx;
   logic [15:0] hb_cnt, hb_cnt_nx;
   logic [2:0]  half_cnt, half_cnt_nx;
   logic [3:0]  bit_cnt, bit_cnt_nx;
   logic [31:0] gap_cnt, gap_cnt_nx;
   logic [15:0] data_q, data_nx;
   logic        cmd_q, cmd_nx;
   logic        par_q, par_nx;
   logic [1:0]  diff_nx;
   logic        tready_nx, busy_nx, err_nx;
   logic        hb_end, accept, legal, lvl, bit_val;
   logic        unused_tuser;

   // Low sync-type bits carry no meaning for the transmitter.
   assign unused_tuser = ^s_axis_tuser[4:0];
   assign dbg_state    = state;

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_nx    = state;
      hb_cnt_nx   = hb_cnt;
      half_cnt_nx = half_cnt;
      bit_cnt_nx  = bit_cnt;
      gap_cnt_nx  = gap_cnt;
      data_nx     = data_q;
      cmd_nx      = cmd_q;
      par_nx      = par_q;
      diff_nx     = 2'b00;
      err_nx      = 1'b0;
      lvl         = 1'b0;
      bit_val     = 1'b0;
      hb_end      = (hb_cnt == 16'(HB - 1));
      accept      = s_axis_tvalid && s_axis_tready;
      legal       = (s_axis_tuser[7:5] == 3'b100) || (s_axis_tuser[7:5] == 3'b010);
      case (state)
         IDLE: begin
            hb_cnt_nx   = 16'd0;
            half_cnt_nx = 3'd0;
            bit_cnt_nx  = 4'd0;
            gap_cnt_nx  = 32'd0;
            if (accept) begin
               if (legal) begin
                  state_nx = SYNC;
                  data_nx  = s_axis_tdata;
                  cmd_nx   = s_axis_tuser[7];
                  // parity_set=1 makes the 17-bit ones count odd, 0 makes it even
                  par_nx   = (^s_axis_tdata) ^ parity_set;
               end else begin
                  err_nx = 1'b1;
               end
            end
         end
         SYNC: begin
            // three half-bit slots per level; command sync starts low on diff[0]
            lvl       = (half_cnt < 3'd3) ? ~cmd_q : cmd_q;
            diff_nx   = {~lvl, lvl};
            hb_cnt_nx = hb_end ? 16'd0 : hb_cnt + 16'd1;
            if (hb_end) begin
               if (half_cnt == 3'd5) begin
                  half_cnt_nx = 3'd0;
                  state_nx    = DATA;
               end else begin
                  half_cnt_nx = half_cnt + 3'd1;
               end
            end
         end
         DATA, PAR: begin
            bit_val   = (state == DATA) ? data_q[15] : par_q;
            // logic 1 is low-then-high on diff[0]
            lvl       = ((half_cnt == 3'd0) ? ~bit_val : bit_val) ^ invert_data;
            diff_nx   = {~lvl, lvl};
            hb_cnt_nx = hb_end ? 16'd0 : hb_cnt + 16'd1;
            if (hb_end) begin
               if (half_cnt == 3'd0) begin
                  half_cnt_nx = 3'd1;
               end else begin
                  half_cnt_nx = 3'd0;
                  if (state == DATA) begin
                     data_nx = {data_q[14:0], 1'b0};
                     if (bit_cnt == 4'd15) begin
                        bit_cnt_nx = 4'd0;
                        state_nx   = PAR;
                     end else begin
                        bit_cnt_nx = bit_cnt + 4'd1;
                     end
                  end else begin
                     state_nx = (GAP_CYC == 0) ? IDLE : GAP;
                  end
               end
            end
         end
         GAP: begin
            gap_cnt_nx = gap_cnt + 32'd1;
            if (gap_cnt == 32'(GAP_CYC - 1)) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      tready_nx = (state_nx == IDLE);
      busy_nx   = (state_nx != IDLE);
   end

   // State, counters, latched word and registered outputs.
   always_ff @(posedge aclk) begin
      if (!arstn) begin
         state         <= IDLE;
         hb_cnt        <= 16'd0;
         half_cnt      <= 3'd0;
         bit_cnt       <= 4'd0;
         gap_cnt       <= 32'd0;
         data_q        <= 16'd0;
         cmd_q         <= 1'b0;
         par_q         <= 1'b0;
         diff          <= 2'b00;
         busy          <= 1'b0;
         tx_err        <= 1'b0;
         s_axis_tready <= 1'b0;
      end else begin
         state         <= state_nx;
         hb_cnt        <= hb_cnt_nx;
         half_cnt      <= half_cnt_nx;
         bit_cnt       <= bit_cnt_nx;
         gap_cnt       <= gap_cnt_nx;
         data_q        <= data_nx;
         cmd_q         <= cmd_nx;
         par_q         <= par_nx;
         diff          <= diff_nx;
         busy          <= busy_nx;
         tx_err        <= err_nx;
         s_axis_tready <= tready_nx;
      end
   end

endmodule

// File: tb/tb_axis_1553_encoder.sv
// Directed bench for axis_1553_encoder at default parameters
// (CPB = 20, HB = 10, 4 gap bits = 80 idle cycles).
// Capture index k is the k-th rising edge after the accepting edge N,
// sampled 1 time unit after that edge.
module tb_axis_1553_encoder;

  logic        aclk = 1'b0;
  logic        arstn = 1'b0;
  logic        parity_set = 1'b0;
  logic [15:0] s_axis_tdata = 16'h0000;
  logic [7:0]  s_axis_tuser = 8'h00;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [1:0]  diff;
  logic        busy;
  logic        tx_err;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] cap_d [0:600];
  logic       cap_r [0:600];
  logic       cap_b [0:600];
  logic       cap_e [0:600];

  logic [16:0] exp_q[$];

  axis_1553_encoder dut (
    .aclk          (aclk),
    .arstn         (arstn),
    .parity_set    (parity_set),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .diff          (diff),
    .busy          (busy),
    .tx_err        (tx_err),
    .dbg_state     (dbg_state)
  );

  // clock / watchdog
  always #5 aclk = ~aclk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected diff[0] for capture k (1..400) of a word, before inversion.
  function automatic logic exp_lvl(input logic [15:0] d, input logic cmd, input logic p, input int k);
    int i, j, b;
    logic v;
    i = k - 1;
    if (i < 60) return (i < 30) ? ~cmd : cmd;
    j = i - 60;
    b = j / 20;
    v = (b < 16) ? d[15 - b] : p;
    return (((j % 20) / 10) == 0) ? ~v : v;
  endfunction

  // driver: present a beat and hold it until the accepting edge
  task automatic send(input logic [15:0] d, input logic [7:0] u, input logic p, input bit hold, output bit ok);
    int waited;
    @(negedge aclk);
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    parity_set    = p;
    s_axis_tvalid = 1'b1;
    waited = 0;
    while (s_axis_tready !== 1'b1 && waited < 1000) begin
      @(negedge aclk);
      waited++;
    end
    ok = (s_axis_tready === 1'b1);
    if (ok) begin
      @(posedge aclk);
      #1;
    end
    if (!hold || !ok) s_axis_tvalid = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int k = 1; k <= n; k++) begin
      @(posedge aclk);
      #1;
      cap_d[k] = diff;
      cap_r[k] = s_axis_tready;
      cap_b[k] = busy;
      cap_e[k] = tx_err;
    end
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b want 0", s_axis_tready); end
    n_checks++; if (diff !== 2'b00) begin n_fail++; $display("FAIL rst_diff: got %b want 00", diff); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (tx_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", tx_err); end
    arstn = 1'b1;
    @(posedge aclk);
    #1;
    n_checks++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL rst_release_tready: got %b want 1", s_axis_tready); end
    n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_cmd_word();
    bit ok;
    int bad;
    logic e;
    int ks[8];
    logic [1:0] ev[8];
    ks = '{1, 30, 31, 60, 61, 71, 381, 391};
    ev = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    send(16'hA5A5, 8'h80, 1'b1, 1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t1_accept: tready not seen within 1000 cycles"); end
    parity_set   = 1'b0;
    s_axis_tdata = 16'h1234;
    capture(480);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (cap_d[ks[i]] !== ev[i]) begin n_fail++; $display("FAIL t1_spot k=%0d: got %b want %b", ks[i], cap_d[ks[i]], ev[i]); end
    end
    bad = 0;
    for (int k = 1; k <= 400; k++) begin
      e = exp_lvl(16'hA5A5, 1'b1, 1'b1, k);
      if (cap_d[k] !== {~e, e}) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL t1_wave: %0d of 400 samples wrong, want 0", bad); end
    bad = 0;
    for (int k = 401; k <= 480; k++) if (cap_d[k] !== 2'b00) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL t1_gap_line: %0d non-idle samples, want 0", bad); end
    n_checks++; if (cap_b[1] !== 1'b1) begin n_fail++; $display("FAIL t1_busy: got %b want 1", cap_b[1]); end
    n_checks++; if (cap_r[479] !== 1'b0) begin n_fail++; $display("FAIL t1_tready_early: got %b want 0", cap_r[479]); end
    n_checks++; if (cap_r[480] !== 1'b1) begin n_fail++; $display("FAIL t1_tready_back: got %b want 1", cap_r[480]); end
    n_checks++; if (cap_b[480] !== 1'b0) begin n_fail++; $display("FAIL t1_busy_end: got %b want 0", cap_b[480]); end
  endtask

  task automatic test_data_word();
    bit ok;
    int bad;
    logic e;
    int ks[6];
    logic [1:0] ev[6];
    ks = '{1, 31, 61, 71, 381, 391};
    ev = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    send(16'h0000, 8'h40, 1'b0, 1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t2_accept: tready not seen within 1000 cycles"); end
    capture(480);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (cap_d[ks[i]] !== ev[i]) begin n_fail++; $display("FAIL t2_spot k=%0d: got %b want %b", ks[i], cap_d[ks[i]], ev[i]); end
    end
    bad = 0;
    for (int k = 1; k <= 400; k++) begin
      e = exp_lvl(16'h0000, 1'b0, 1'b0, k);
      if (cap_d[k] !== {~e, e}) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL t2_wave: %0d of 400 samples wrong, want 0", bad); end
  endtask

  // tvalid held: the next word is taken at the earliest edge, N+1+400+80.
  task automatic test_back_to_back();
    bit ok;
    int bad;
    logic e;
    send(16'h0001, 8'h80, 1'b1, 1'b1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t3_accept1: tready not seen within 1000 cycles"); end
    s_axis_tdata = 16'hFFFE;
    s_axis_tuser = 8'h40;
    capture(480);
    @(posedge aclk);
    #1;
    cap_d[481] = diff;
    cap_r[481] = s_axis_tready;
    cap_b[481] = busy;
    s_axis_tvalid = 1'b0;
    bad = 0;
    for (int k = 1; k <= 400; k++) begin
      e = exp_lvl(16'h0001, 1'b1, 1'b0, k);
      if (cap_d[k] !== {~e, e}) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL t3_wave1: %0d of 400 samples wrong, want 0", bad); end
    bad = 0;
    for (int k = 401; k <= 481; k++) if (cap_d[k] !== 2'b00) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL t3_idle: %0d non-idle samples in gap, want 0", bad); end
    n_checks++; if (cap_r[479] !== 1'b0 || cap_r[480] !== 1'b1) begin n_fail++; $display("FAIL t3_ready_edge: got %b%b want 01", cap_r[479], cap_r[480]); end
    n_checks++; if (cap_r[481] !== 1'b0 || cap_b[481] !== 1'b1) begin n_fail++; $display("FAIL t3_accept2_at_481: tready=%b busy=%b want 0 1", cap_r[481], cap_b[481]); end
    capture(401);
    bad = 0;
    for (int k = 1; k <= 400; k++) begin
      e = exp_lvl(16'hFFFE, 1'b0, 1'b0, k);
      if (cap_d[k] !== {~e, e}) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL t3_wave2: %0d of 400 samples wrong, want 0", bad); end
    n_checks++; if (cap_d[401] !== 2'b00) begin n_fail++; $display("FAIL t3_end2: got %b want 00", cap_d[401]); end
    capture(80);
  endtask

  task automatic test_illegal();
    bit ok;
    send(16'h1234, 8'hE0, 1'b0, 1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t4_accept: tready not seen within 1000 cycles"); end
    n_checks++; if (tx_err !== 1'b1) begin n_fail++; $display("FAIL t4_err_pulse: got %b want 1", tx_err); end
    n_checks++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL t4_tready: got %b want 1", s_axis_tready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t4_busy: got %b want 0", busy); end
    capture(30);
    n_checks++; if (cap_e[1] !== 1'b0) begin n_fail++; $display("FAIL t4_err_width: got %b want 0", cap_e[1]); end
    n_checks++; if (cap_d[1] !== 2'b00 || cap_d[30] !== 2'b00 || cap_b[30] !== 1'b0) begin n_fail++; $display("FAIL t4_line: diff=%b/%b busy=%b want 00/00 0", cap_d[1], cap_d[30], cap_b[30]); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bad;
    send(16'hA5A5, 8'h80, 1'b1, 1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t5_accept: tready not seen within 1000 cycles"); end
    capture(200);
    n_checks++; if (cap_d[200] === 2'b00) begin n_fail++; $display("FAIL t5_active: got %b want non-idle", cap_d[200]); end
    arstn = 1'b0;
    @(posedge aclk);
    #1;
    n_checks++; if (diff !== 2'b00 || s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL t5_reset_edge: diff=%b tready=%b want 00 0", diff, s_axis_tready); end
    arstn = 1'b1;
    @(posedge aclk);
    #1;
    n_checks++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL t5_tready: got %b want 1", s_axis_tready); end
    capture(500);
    bad = 0;
    for (int k = 1; k <= 500; k++) if (cap_d[k] !== 2'b00 || cap_b[k] !== 1'b0) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL t5_residual: %0d active samples, want 0", bad); end
  endtask

  // Bench-side Manchester decoder with a scoreboard of expected words.
  task automatic test_loopback();
    bit ok;
    logic [15:0] d, dd;
    logic [7:0]  u;
    logic        p, cmd_dec, par_dec;
    logic [16:0] exp_w;
    int bad;
    for (int w = 0; w < 100; w++) begin
      d = 16'($urandom_range(0, 65535));
      u = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h40;
      u[4:0] = 5'($urandom_range(0, 31));
      p = 1'($urandom_range(0, 1));
      send(d, u, p, 1'b0, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL t6_accept w=%0d: tready not seen", w); end
      exp_q.push_back({u[7], d});
      capture(480);
      cmd_dec = (cap_d[5] == 2'b10) && (cap_d[35] == 2'b01);
      bad = 0;
      for (int b = 0; b < 17; b++) begin
        if (cap_d[65 + 20 * b] !== ~cap_d[75 + 20 * b]) bad++;
        if (cap_d[65 + 20 * b] !== 2'b01 && cap_d[65 + 20 * b] !== 2'b10) bad++;
      end
      for (int b = 0; b < 16; b++) dd[15 - b] = ~cap_d[65 + 20 * b][0];
      par_dec = ~cap_d[385][0];
      exp_w = exp_q.pop_front();
      n_checks++; if ({cmd_dec, dd} !== exp_w) begin n_fail++; $display("FAIL t6_word w=%0d: got %h want %h", w, {cmd_dec, dd}, exp_w); end
      n_checks++; if (((^dd) ^ par_dec) !== p) begin n_fail++; $display("FAIL t6_parity w=%0d: got %b want %b", w, (^dd) ^ par_dec, p); end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL t6_coding w=%0d: %0d bad bit cells, want 0", w, bad); end
    end
  endtask

  initial begin
    test_reset();
    test_cmd_word();
    test_data_word();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
